id_ex_reg: RTL
==============

# id_ex_reg

ID/EX pipeline register for the 5-stage MIPS pipeline. It captures the decode-stage bundle (control bits, NPC, register operands, sign-extended immediate, rt/rd) on each clock and presents it to the EX stage. It inserts bubbles on flush and on a load-use hazard, raising a stall back to the PC and IF/ID registers. It keeps a saturating count of inserted load-use bubbles for performance debug.

## Interface
Parameters:
- CNT_W, 16, width of the bubble counter

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  the IF/ID register holds a real instruction
- id_control_bits  in  9  {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op[1:0]}, bit 8 down to 0
- id_npc  in  32  next PC from decode
- id_reg_rs  in  32  register file read data 1
- id_reg_rt  in  32  register file read data 2
- id_sign_ext  in  32  sign-extended immediate
- id_rs  in  5  instr[25:21]
- id_rt  in  5  instr[20:16]
- id_rd  in  5  instr[15:11]
- flush  in  1  branch taken; kill the instruction entering EX
- hold  in  1  downstream freeze; keep the current contents
- ex_valid  out  1  EX-side contents are a real instruction
- ex_control_bits, ex_npc, ex_reg_rs, ex_reg_rt, ex_sign_ext, ex_rt, ex_rd  out  9/32/32/32/32/5/5  registered copies of the id_* fields
- stall_id  out  1  freeze the PC and IF/ID registers this cycle (combinational)
- bubble_count  out  CNT_W  number of load-use bubbles inserted, saturating

## Operation
- load_use = ex_valid & ex_control_bits[4] (mem_read) & id_valid & (ex_rt != 0) & ((ex_rt == id_rs) | ((ex_rt == id_rt) & uses_rt)).
- uses_rt = id_control_bits[8] | id_control_bits[3] | id_control_bits[2] (R-type, store, branch).
- stall_id = load_use & ~flush & ~hold, or hold.
- Per-edge update, in priority order:
  1. flush: the register becomes a bubble (ex_valid=0, ex_control_bits=0, other fields 0).
  2. hold: all outputs keep their values.
  3. load_use: the register becomes a bubble and bubble_count increments.
  4. Otherwise, load all id_* fields and set ex_valid=id_valid.
- A bubble zeroes every control bit, so a bubble never writes registers or memory and never branches.
- If id_valid=0 in the normal case, the fields are still loaded, but ex_control_bits is forced to 0.
- bubble_count saturates at all-ones. A flush or hold never increments it.

## Timing
- Reset, asynchronous: every output register is 0, including ex_valid, all fields and bubble_count.
- Latency: 1 cycle from id_* to ex_*.
- stall_id is valid in the same cycle as the id_* inputs and carries no registered delay.
- A load-use hazard stalls for exactly one cycle. On the next edge the bubble clears ex_valid, so load_use drops and the held instruction loads on the following edge.
- Flush and load_use in the same cycle: flush wins, stall_id=0 and no count.
- Hold and load_use in the same cycle: the register holds, stall_id=1 and no count. The hazard is re-evaluated after hold releases.
- Reset asserted mid-stall: outputs clear at once, and stall_id falls because ex_valid=0.

## Configuration
- ID_EX_HAZARD_EN defined: load-use detection, bubble insertion and bubble_count behave as specified above.
- ID_EX_HAZARD_EN undefined:
  - load_use is constant 0, so stall_id = hold.
  - bubble_count is tied to 0.
  - The counter and comparators are not synthesized.

## Structure
- Shared package pipe_pkg holds:
  - Control-bit index constants: CB_REG_DST=8, CB_ALU_SRC=7, CB_MEM_TO_REG=6, CB_REG_WRITE=5, CB_MEM_READ=4, CB_MEM_WRITE=3, CB_BRANCH=2, CB_ALU_OP_HI=1, CB_ALU_OP_LO=0.
  - CTRL_W=9 and REG_ZERO=5'd0.
- One sub-module, load_use_detect, is purely combinational and contains the comparators and load_use. It is instantiated only under ID_EX_HAZARD_EN.

## Test plan
- Reset: assert rst mid-clock with non-zero inputs -> all outputs 0 immediately; after release, one normal load puts id_npc=0x00000010 onto ex_npc.
- Load-use: EX holds lw with ex_rt=5, ID holds add with id_rs=5 -> stall_id=1, next edge ex_valid=0 and ex_control_bits=0, bubble_count=1, following edge the add loads.
- No false hazard:
  - lw with ex_rt=0 against id_rs=0 -> stall_id=0 and no bubble.
  - addi (uses_rt=0) with id_rt equal to the load rt -> no stall.
- Flush priority: flush=1 together with a load-use condition -> stall_id=0, bubble inserted, bubble_count unchanged.
- Hold: hold=1 for 3 cycles with changing id_* -> ex_* stable and stall_id=1; counter unchanged.
- Saturation: CNT_W=2, drive 5 consecutive load-use hazards -> bubble_count reads 3 and stays at 3.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control-bit positions and common widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_pkg;

  localparam int CTRL_W = 9;

  // Bit positions inside the 9-bit decode control bundle
  localparam int CB_REG_DST   = 8;
  localparam int CB_ALU_SRC   = 7;
  localparam int CB_MEM_TO_REG = 6;
  localparam int CB_REG_WRITE = 5;
  localparam int CB_MEM_READ  = 4;
  localparam int CB_MEM_WRITE = 3;
  localparam int CB_BRANCH    = 2;
  localparam int CB_ALU_OP_HI = 1;
  localparam int CB_ALU_OP_LO = 0;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/id_ex_reg_if.sv
// ID/EX bundle: decode-side fields in, EX-side registered copies out.
// Latency: wires only; the register itself lives in id_ex_reg.
// Backpressure: hold freezes EX, stall_id freezes PC and IF/ID.
interface id_ex_if
  import pipe_pkg::*;
#(
  parameter int CNT_W = 16
);

  // Decode side
  logic              id_valid;
  logic [CTRL_W-1:0] id_control_bits;
  logic [31:0]       id_npc;
  logic [31:0]       id_reg_rs;
  logic [31:0]       id_reg_rt;
  logic [31:0]       id_sign_ext;
  logic [4:0]        id_rs;
  logic [4:0]        id_rt;
  logic [4:0]        id_rd;
  logic              flush;
  logic              hold;

  // Execute side
  logic              ex_valid;
  logic [CTRL_W-1:0] ex_control_bits;
  logic [31:0]       ex_npc;
  logic [31:0]       ex_reg_rs;
  logic [31:0]       ex_reg_rt;
  logic [31:0]       ex_sign_ext;
  logic [4:0]        ex_rt;
  logic [4:0]        ex_rd;
  logic              stall_id;
  logic [CNT_W-1:0]  bubble_count;

  modport master (
    output id_valid, id_control_bits, id_npc, id_reg_rs, id_reg_rt, id_sign_ext,
           id_rs, id_rt, id_rd, flush, hold,
    input  ex_valid, ex_control_bits, ex_npc, ex_reg_rs, ex_reg_rt, ex_sign_ext,
           ex_rt, ex_rd, stall_id, bubble_count
  );

  modport slave (
    input  id_valid, id_control_bits, id_npc, id_reg_rs, id_reg_rt, id_sign_ext,
           id_rs, id_rt, id_rd, flush, hold,
    output ex_valid, ex_control_bits, ex_npc, ex_reg_rs, ex_reg_rt, ex_sign_ext,
           ex_rt, ex_rd, stall_id, bubble_count
  );

endinterface

// File: rtl/id_ex_reg_load_use_detect.sv
// Load-use hazard detector: a load in EX whose destination is read by the instruction in ID.
// Latency: purely combinational.
// Backpressure: none; its output feeds the bubble/stall decision in id_ex_reg.
module load_use_detect
  import pipe_pkg::*;
(
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  input  logic       id_valid,
  input  logic       id_reg_dst,
  input  logic       id_mem_write,
  input  logic       id_branch,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  output logic       load_use
);

  logic uses_rt;
  logic rs_match;
  logic rt_match;

  // R-type, store and branch read rt as a source; immediates only write it
  assign uses_rt  = id_reg_dst | id_mem_write | id_branch;
  assign rs_match = (ex_rt == id_rs);
  assign rt_match = (ex_rt == id_rt) & uses_rt;

  // $zero is never a real dependency
  assign load_use = ex_valid & ex_mem_read & id_valid & (ex_rt != REG_ZERO)
                  & (rs_match | rt_match);

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with flush/load-use bubbles; ID_EX_HAZARD_EN enables hazard logic.
// Latency: 1 cycle id_* -> ex_*; stall_id is combinational in the same cycle.
// Backpressure: hold freezes contents and stalls ID; a load-use hazard stalls ID one cycle.
module id_ex_reg
  import pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic   clk,
  input logic   rst,
  id_ex_if.slave bus
);

  logic              ex_valid_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [31:0]       npc_q;
  logic [31:0]       reg_rs_q;
  logic [31:0]       reg_rt_q;
  logic [31:0]       sext_q;
  logic [4:0]        rt_q;
  logic [4:0]        rd_q;
  logic              load_use;

`ifdef ID_EX_HAZARD_EN
  logic [CNT_W-1:0] bubble_cnt_q;

  load_use_detect u_load_use_detect (
    .ex_valid     (ex_valid_q),
    .ex_mem_read  (ctrl_q[CB_MEM_READ]),
    .ex_rt        (rt_q),
    .id_valid     (bus.id_valid),
    .id_reg_dst   (bus.id_control_bits[CB_REG_DST]),
    .id_mem_write (bus.id_control_bits[CB_MEM_WRITE]),
    .id_branch    (bus.id_control_bits[CB_BRANCH]),
    .id_rs        (bus.id_rs),
    .id_rt        (bus.id_rt),
    .load_use     (load_use)
  );

  // Count only bubbles that actually get inserted; flush and hold take precedence
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt_q <= '0;
    end else if (load_use && !bus.flush && !bus.hold && (bubble_cnt_q != '1)) begin
      bubble_cnt_q <= bubble_cnt_q + 1'b1;
    end
  end

  assign bus.bubble_count = bubble_cnt_q;
`else
  // rs is only needed for hazard compare; sink it so the default build stays warning-free
  logic unused_id_rs;
  assign unused_id_rs     = ^bus.id_rs;
  assign load_use         = 1'b0;
  assign bus.bubble_count = '0;
`endif

  // Pipeline register: flush > hold > load-use bubble > normal load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      ctrl_q     <= '0;
      npc_q      <= '0;
      reg_rs_q   <= '0;
      reg_rt_q   <= '0;
      sext_q     <= '0;
      rt_q       <= '0;
      rd_q       <= '0;
    end else if (bus.flush || (!bus.hold && load_use)) begin
      ex_valid_q <= 1'b0;
      ctrl_q     <= '0;
      npc_q      <= '0;
      reg_rs_q   <= '0;
      reg_rt_q   <= '0;
      sext_q     <= '0;
      rt_q       <= '0;
      rd_q       <= '0;
    end else if (!bus.hold) begin
      ex_valid_q <= bus.id_valid;
      // An empty slot must never carry side-effecting control
      ctrl_q     <= bus.id_valid ? bus.id_control_bits : '0;
      npc_q      <= bus.id_npc;
      reg_rs_q   <= bus.id_reg_rs;
      reg_rt_q   <= bus.id_reg_rt;
      sext_q     <= bus.id_sign_ext;
      rt_q       <= bus.id_rt;
      rd_q       <= bus.id_rd;
    end
  end

  // A flush kills the ID instruction anyway, so it does not need to be stalled
  assign bus.stall_id = bus.hold | (load_use & ~bus.flush);

  assign bus.ex_valid        = ex_valid_q;
  assign bus.ex_control_bits = ctrl_q;
  assign bus.ex_npc          = npc_q;
  assign bus.ex_reg_rs       = reg_rs_q;
  assign bus.ex_reg_rt       = reg_rt_q;
  assign bus.ex_sign_ext     = sext_q;
  assign bus.ex_rt           = rt_q;
  assign bus.ex_rd           = rd_q;

endmodule
